// File: rtl/mem_stage_access_pkg.sv
// mem_stage_access_pkg: shared pipeline constants, MEM-stage FSM states and the MEM/WB bundle.
package mem_stage_access_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       alu_result;
    logic [XLEN-1:0]       read_data;
  } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register with load-enable; when not loading, valid can be dropped while payload holds.
module mem_wb_reg
  import mem_stage_access_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load_i,
  input  logic    clr_i,
  input  mem_wb_t d_i,
  output mem_wb_t q_o
);
  always_ff @(posedge clk) begin
    if (rst) q_o <= '0;
    else if (load_i) q_o <= d_i;
    else if (clr_i) q_o.valid <= 1'b0;
  end
endmodule

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM-stage controller issuing loads/stores over req/ready with stall and timeout abort.
module mem_stage_access
  import mem_stage_access_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_alu_result,
  output logic [XLEN-1:0]   wb_read_data,
  output logic              mem_error
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              memop, in_access, timeout, done, issue, wb_load;
  mem_wb_t           wb_d, wb_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    memop     = ex_valid & (ex_mem_read | ex_mem_write);
    in_access = state_q == ACCESS;
    timeout   = in_access && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    done      = in_access & (dmem_ready | timeout);
    state_d   = in_access ? (done ? IDLE : ACCESS) : (memop ? ACCESS : IDLE);
  end
  // A timed-out access still retires its instruction, but never writes the register file.
  always_comb begin
    issue              = ~in_access & memop;
    stall              = in_access ? ~done : memop;
    wb_load            = in_access ? done : ex_valid & ~memop;
    wb_d.valid         = 1'b1;
    wb_d.reg_write     = ex_reg_write & ~(in_access & ~dmem_ready);
    wb_d.mem_to_reg    = ex_mem_to_reg;
    wb_d.rd            = ex_rd;
    wb_d.alu_result    = ex_alu_result;
    wb_d.read_data     = (in_access & dmem_ready & ~we_q) ? dmem_rdata : '0;
    req_d              = issue | (req_q & ~done);
    we_d               = issue ? ex_mem_write : we_q;
    addr_d             = issue ? ex_alu_result[ADDR_W-1:0] : addr_q;
    wdata_d            = issue ? ex_store_data : wdata_q;
    cnt_d              = issue ? '0 : (in_access & ~done) ? cnt_q + CW'(1) : cnt_q;
    err_d              = err_q | (timeout & ~dmem_ready);
  end
  mem_wb_reg u_mem_wb_reg (
    .clk   (clock),
    .rst   (reset),
    .load_i(wb_load),
    .clr_i (~wb_load),
    .d_i   (wb_d),
    .q_o   (wb_q)
  );
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign mem_error     = err_q;
  assign wb_valid      = wb_q.valid;
  assign wb_reg_write  = wb_q.reg_write;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_rd         = wb_q.rd;
  assign wb_alu_result = wb_q.alu_result;
  assign wb_read_data  = wb_q.read_data;
endmodule
